// File: rtl/adc_capture_offset.sv
// Serial ADC capture. Each frame has LEAD_ZEROS leading bits and then DATA_W
// payload bits, MSB first. Each result is reported raw and also as a signed
// value with OFFSET subtracted.
// Handshake: valid is a one-cycle strobe with no back-pressure. It is high
// only in the DONE cycle. zeros, dato, dato_out and lead_err change only on
// that cycle and hold their values until the next strobe.
module adc_capture_offset #(
  parameter int DATA_W     = 12,
  parameter int LEAD_ZEROS = 4,
  parameter int OUT_W      = 22,
  parameter int OFFSET     = 2048,
  parameter int SCLK_DIV   = 2,
  parameter int QUIET_CYC  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  cont,
  input  logic                  data_in,
  output logic                  cs,
  output logic                  sclk,
  output logic [LEAD_ZEROS-1:0] zeros,
  output logic [DATA_W-1:0]     dato,
  output logic [OUT_W-1:0]      dato_out,
  output logic                  valid,
  output logic                  lead_err,
  output logic                  busy,
  output logic [2:0]            state_dbg
);

  localparam int FRAME_BITS = LEAD_ZEROS + DATA_W;
  localparam int CNT_MAX    = (SCLK_DIV > QUIET_CYC) ? SCLK_DIV : QUIET_CYC;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);
  localparam int BIT_W      = $clog2(FRAME_BITS + 1);

  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(SCLK_DIV - 1);
  localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(QUIET_CYC - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_BITS - 1);
  localparam logic [OUT_W-1:0] OFFSET_W   = OUT_W'(OFFSET);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_DONE  = 3'd3,
    S_QUIET = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
  logic                    pending_q, pending_d;
  logic                    cs_q, cs_d;
  logic                    sclk_q, sclk_d;
  logic                    valid_q, valid_d;
  logic                    busy_q, busy_d;
  logic                    lead_err_q, lead_err_d;
  logic [LEAD_ZEROS-1:0]   zeros_q, zeros_d;
  logic [DATA_W-1:0]       dato_q, dato_d;
  logic [OUT_W-1:0]        dato_out_q, dato_out_d;

  // Next-state, shift and result logic. cs, sclk and busy are registered from
  // the next state, so the pins are glitch-free and change together with the
  // state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    pending_d  = pending_q;
    sclk_d     = 1'b1;
    valid_d    = 1'b0;
    lead_err_d = lead_err_q;
    zeros_d    = zeros_q;
    dato_d     = dato_q;
    dato_out_d = dato_out_q;

    // Requests that arrive while a frame is in flight collapse into one flag.
    if (start && (state_q != S_IDLE)) pending_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start || cont) begin
          state_d = S_SETUP;
          cnt_d   = '0;
        end
      end
      S_SETUP: begin
        if (cnt_q == DIV_LAST) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
          sclk_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SHIFT: begin
        if (!sclk_q) begin
          // Low half-period. The edge that raises sclk also samples data_in.
          if (cnt_q == DIV_LAST) begin
            sclk_d  = 1'b1;
            cnt_d   = '0;
            shreg_d = {shreg_q[FRAME_BITS-2:0], data_in};
          end else begin
            sclk_d = 1'b0;
            cnt_d  = cnt_q + CNT_W'(1);
          end
        end else if (bit_q == BIT_LAST) begin
          // The last bit is complete once it is sampled, so its high phase
          // lasts only one cycle before DONE.
          state_d    = S_DONE;
          valid_d    = 1'b1;
          zeros_d    = shreg_q[FRAME_BITS-1 -: LEAD_ZEROS];
          dato_d     = shreg_q[DATA_W-1:0];
          dato_out_d = OUT_W'(shreg_q[DATA_W-1:0]) - OFFSET_W;
          lead_err_d = |shreg_q[FRAME_BITS-1 -: LEAD_ZEROS];
        end else if (cnt_q == DIV_LAST) begin
          sclk_d = 1'b0;
          cnt_d  = '0;
          bit_d  = bit_q + BIT_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_QUIET;
        cnt_d   = '0;
      end
      S_QUIET: begin
        if (cnt_q == QUIET_LAST) begin
          cnt_d   = '0;
          state_d = (cont || pending_q || start) ? S_SETUP : S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // A new frame consumes the pending request.
    if ((state_d == S_SETUP) && (state_q != S_SETUP)) pending_d = 1'b0;

    cs_d   = !((state_d == S_SETUP) || (state_d == S_SHIFT));
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers. Reset idles the ADC bus at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      pending_q  <= 1'b0;
      cs_q       <= 1'b1;
      sclk_q     <= 1'b1;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      lead_err_q <= 1'b0;
      zeros_q    <= '0;
      dato_q     <= '0;
      dato_out_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      pending_q  <= pending_d;
      cs_q       <= cs_d;
      sclk_q     <= sclk_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      lead_err_q <= lead_err_d;
      zeros_q    <= zeros_d;
      dato_q     <= dato_d;
      dato_out_q <= dato_out_d;
    end
  end

  assign cs        = cs_q;
  assign sclk      = sclk_q;
  assign valid     = valid_q;
  assign busy      = busy_q;
  assign lead_err  = lead_err_q;
  assign zeros     = zeros_q;
  assign dato      = dato_q;
  assign dato_out  = dato_out_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_adc_capture_offset.sv
// Bench for adc_capture_offset. A behavioural ADC serves frames from a queue.
// A reference function turns each frame into the expected result word and the
// cycle in which it is due. A monitor pops and compares results on every
// valid strobe and also checks bus shape and result holding.
module tb_adc_capture_offset;

  localparam int DATA_W     = 12;
  localparam int LEAD_ZEROS = 4;
  localparam int OUT_W      = 22;
  localparam int OFFSET     = 2048;
  localparam int SCLK_DIV   = 2;
  localparam int QUIET_CYC  = 8;
  localparam int FB         = LEAD_ZEROS + DATA_W;
  localparam int LAT        = 2 + 2 * SCLK_DIV * FB;
  localparam int PERIOD     = LAT + QUIET_CYC;
  localparam int RW         = 1 + LEAD_ZEROS + DATA_W + OUT_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic cont = 1'b0;
  logic data_in = 1'b0;
  logic cs, sclk, valid, lead_err, busy;
  logic [LEAD_ZEROS-1:0] zeros;
  logic [DATA_W-1:0]     dato;
  logic [OUT_W-1:0]      dato_out;
  logic [2:0]            state_dbg;

  adc_capture_offset #(
    .DATA_W(DATA_W), .LEAD_ZEROS(LEAD_ZEROS), .OUT_W(OUT_W),
    .OFFSET(OFFSET), .SCLK_DIV(SCLK_DIV), .QUIET_CYC(QUIET_CYC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .data_in(data_in),
    .cs(cs), .sclk(sclk), .zeros(zeros), .dato(dato), .dato_out(dato_out),
    .valid(valid), .lead_err(lead_err), .busy(busy), .state_dbg(state_dbg)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  logic [RW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  logic [FB-1:0] frame_q[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference: leading field, payload, payload minus offset as a signed value
  // at OUT_W bits, and the OR of the leading field.
  function automatic logic [RW-1:0] model(input logic [FB-1:0] fr);
    logic [LEAD_ZEROS-1:0] z;
    logic [DATA_W-1:0]     p;
    logic [OUT_W-1:0]      o;
    z = fr[FB-1 -: LEAD_ZEROS];
    p = fr[DATA_W-1:0];
    o = OUT_W'(int'(p) - OFFSET);
    return {(z != '0), z, p, o};
  endfunction

  // ADC model: a new frame starts when cs falls, and the next bit appears
  // after each rising sclk.
  logic [FB-1:0] adc_cur = '0;
  int            adc_idx = 0;
  bit            adc_act = 0;
  logic          adc_sclk_p = 1'b1;
  always @(negedge clk) begin
    if (cs) begin
      adc_act = 0;
      adc_idx = 0;
    end else if (!adc_act) begin
      adc_act = 1;
      adc_idx = 0;
      if (frame_q.size() > 0) adc_cur = frame_q.pop_front();
      else adc_cur = FB'($urandom);
    end else if (sclk && !adc_sclk_p) begin
      adc_idx++;
    end
    adc_sclk_p = sclk;
    if (adc_act && adc_idx < FB) data_in = adc_cur[FB-1-adc_idx];
    else data_in = 1'($urandom);
  end

  // Monitor
  logic [RW-1:0] hold_val = '0;
  logic [RW-1:0] e;
  int   ec;
  logic valid_p = 1'b0, cs_p = 1'b1, sclk_p = 1'b1;
  int   rise_cnt = 0, hi_cnt = 0;
  bit   hi_busy = 0;
  always @(negedge clk) begin
    if (!rst) begin
      hold_val = '0; valid_p = 1'b0; cs_p = 1'b1; sclk_p = 1'b1;
      rise_cnt = 0; hi_cnt = 0; hi_busy = 0;
    end else begin
      if (valid) begin
        check("valid_back_to_back", valid_p, 0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid got=%0h exp=none", {lead_err, zeros, dato, dato_out});
        end else begin
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          check("result", {lead_err, zeros, dato, dato_out}, e);
          check("valid_cycle", cyc, ec);
          hold_val = e;
        end
      end else begin
        check("hold", {lead_err, zeros, dato, dato_out}, hold_val);
      end
      if (!cs && sclk && !sclk_p) rise_cnt++;
      if (cs && !cs_p) begin
        check("sclk_rises", rise_cnt, FB);
        rise_cnt = 0;
        hi_cnt   = 1;
        hi_busy  = busy;
      end else if (cs) begin
        hi_cnt++;
        hi_busy = hi_busy && busy;
      end
      if (!cs && cs_p) begin
        if (hi_busy) check("cs_high_gap", hi_cnt, QUIET_CYC + 1);
        hi_busy  = 0;
        rise_cnt = 0;
      end
      valid_p = valid; cs_p = cs; sclk_p = sclk;
    end
  end

  // Driver tasks
  task automatic wait_idle(input int max);
    for (int i = 0; i < max && busy; i++) @(negedge clk);
    check("idle_timeout", busy, 0);
  endtask

  task automatic send_start(input logic [FB-1:0] fr, output int ecyc);
    @(negedge clk);
    ecyc = cyc + LAT;
    frame_q.push_back(fr);
    exp_q.push_back(model(fr));
    exp_cyc_q.push_back(ecyc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  logic [FB-1:0] fr;
  logic [FB-1:0] dir_frames[4];
  int m, ecyc;

  initial begin
    dir_frames[0] = 16'h0FFF;
    dir_frames[1] = 16'h0000;
    dir_frames[2] = 16'h0800;
    dir_frames[3] = 16'h5ABC;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cs", cs, 1);
    check("rst_sclk", sclk, 1);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_result", {lead_err, zeros, dato, dato_out}, 0);
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);

    // Directed single-shot frames
    for (int i = 0; i < 4; i++) begin
      send_start(dir_frames[i], ecyc);
      wait_idle(300);
    end

    // Continuous mode for three frames, with cont cleared during the third
    @(negedge clk);
    m = cyc;
    for (int i = 0; i < 3; i++) begin
      fr = FB'($urandom);
      frame_q.push_back(fr);
      exp_q.push_back(model(fr));
      exp_cyc_q.push_back(m + LAT + i * PERIOD);
    end
    cont = 1'b1;
    repeat (LAT + PERIOD + 40) @(negedge clk);
    cont = 1'b0;
    wait_idle(400);

    // Two start pulses during a frame give exactly one extra frame
    fr = FB'($urandom);
    send_start(fr, ecyc);
    fr = FB'($urandom);
    frame_q.push_back(fr);
    exp_q.push_back(model(fr));
    exp_cyc_q.push_back(ecyc + PERIOD);
    repeat (20) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(400);
    repeat (100) @(negedge clk);
    check("idle_after_pending", busy, 0);

    // Reset during bit 7 aborts the frame
    send_start(FB'($urandom), ecyc);
    for (int i = 0; i < 200 && rise_cnt != 7; i++) @(negedge clk);
    check("reach_bit7", rise_cnt, 7);
    #2 rst = 1'b0;
    #1;
    check("abort_cs", cs, 1);
    check("abort_sclk", sclk, 1);
    check("abort_valid", valid, 0);
    check("abort_busy", busy, 0);
    check("abort_result", {lead_err, zeros, dato, dato_out}, 0);
    void'(exp_q.pop_back());
    void'(exp_cyc_q.pop_back());
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    repeat (10) @(negedge clk);
    check("no_start_after_rst", busy, 0);
    send_start(16'h0123, ecyc);
    wait_idle(300);

    // Random single-shot frames
    for (int i = 0; i < 6; i++) begin
      fr = FB'($urandom);
      if ($urandom_range(0, 1) == 1) fr[FB-1 -: LEAD_ZEROS] = '0;
      repeat ($urandom_range(0, 5)) @(negedge clk);
      send_start(fr, ecyc);
      wait_idle(300);
    end

    repeat (20) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_capture_offset.md
ADC_CAPTURE_OFFSET -- requirements
Module: adc_capture_offset

Interface
REQ-001 SHALL have parameter DATA_W, default 12, ADC payload bits per frame.
REQ-002 SHALL have parameter LEAD_ZEROS, default 4, leading zero bits before payload; FRAME_BITS = LEAD_ZEROS + DATA_W.
REQ-003 SHALL have parameter OUT_W, default 22, signed output width; OUT_W >= DATA_W+1 is required.
REQ-004 SHALL have parameter OFFSET, default 2048, unsigned value subtracted from the payload.
REQ-005 SHALL have parameter SCLK_DIV, default 2, clk cycles per sclk half-period (>= 1).
REQ-006 SHALL have parameter QUIET_CYC, default 8, minimum clk cycles with cs high between frames.
REQ-007 clk  input  1  system clock; all logic on rising edge.
REQ-008 rst  input  1  asynchronous, active-low reset.
REQ-009 start  input  1  single-frame request, sampled per clk.
REQ-010 cont  input  1  1 = continuous conversion, 0 = single-shot.
REQ-011 data_in  input  1  serial data from ADC.
REQ-012 cs  output  1  ADC chip select, active low.
REQ-013 sclk  output  1  ADC serial clock, idles high.
REQ-014 zeros  output  LEAD_ZEROS  raw leading bits of last frame, first-received bit in MSB.
REQ-015 dato  output  DATA_W  raw unsigned payload of last frame, MSB first on the wire.
REQ-016 dato_out  output  OUT_W  signed two's-complement (dato - OFFSET).
REQ-017 valid  output  1  one-cycle strobe: new frame results present.
REQ-018 lead_err  output  1  last frame had a nonzero leading bit.
REQ-019 busy  output  1  high from frame start until end of quiet period.

Function
REQ-020 SHALL implement states IDLE, SETUP, SHIFT, DONE, QUIET.
REQ-021 IDLE: leaves to SETUP on next clk when start=1 or cont=1; cs goes low on that transition.
REQ-022 SETUP: cs low, sclk high for SCLK_DIV cycles, then SHIFT.
REQ-023 SHIFT: sclk low SCLK_DIV cycles then high SCLK_DIV cycles per bit; data_in sampled into the shift register on the clk that drives sclk low->high; exactly FRAME_BITS samples.
REQ-024 DONE (one cycle, entered cycle after the last sample): cs=1, sclk=1; zeros, dato, dato_out, lead_err updated; valid=1.
REQ-025 Latency: valid SHALL assert exactly 2 + 2*SCLK_DIV*FRAME_BITS clk cycles after the cycle in which start was sampled from IDLE (66 at defaults).
REQ-026 QUIET: cs high QUIET_CYC cycles, busy=1; then SETUP if cont=1 or a pending start exists, else IDLE.
REQ-027 start asserted in any non-IDLE state SHALL set a single pending flag (further starts not counted); flag clears when the next frame enters SETUP.
REQ-028 Clearing cont mid-frame SHALL let the current frame complete normally; no truncated frames are ever produced.
REQ-029 dato_out = sign-extended (zero-extended dato minus OFFSET), computed at OUT_W bits, no saturation.
REQ-030 lead_err = OR of the LEAD_ZEROS leading bits; payload is still reported when lead_err=1.
REQ-031 zeros, dato, dato_out, lead_err SHALL hold their values between DONE strobes.
REQ-032 valid SHALL never be high on two consecutive cycles.

Reset
REQ-033 On rst=0, immediately and asynchronously: state IDLE, cs=1, sclk=1, valid=0, busy=0, lead_err=0, zeros=0, dato=0, dato_out=0, pending=0, counters=0.
REQ-034 Reset mid-frame SHALL abort without a valid strobe; after release, no frame starts until start=1 or cont=1 is sampled.

Verification
REQ-035 Defaults, start pulse, ADC model sends 0000 + 0xFFF -> valid at cycle 66, dato=0xFFF, dato_out=+2047, lead_err=0, zeros=0.
REQ-036 ADC sends 0000 + 0x000 -> dato_out=-2048 (0x3FF800 at 22 bits); 0x800 -> dato_out=0.
REQ-037 ADC sends 0101 + 0xABC -> zeros=4'b0101, lead_err=1, dato=0xABC, dato_out=+700.
REQ-038 cont=1 for three frames -> valid strobes spaced 2+64+8 cycles apart, cs high exactly QUIET_CYC+1 cycles between frames, 16 sclk rising edges per frame.
REQ-039 start pulsed twice during a frame -> exactly one extra frame after QUIET, then IDLE.
REQ-040 rst=0 at bit 7 of a frame -> cs, sclk high same cycle, no valid, all outputs 0; next start yields a full correct frame.
